pipe_sel_mux: RTL and testbench
===============================

PIPE_SEL_MUX -- requirements
Module: pipe_sel_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bits per channel.
REQ-002 The block SHALL have parameter NUM_IN, default 4, range 2..16, meaning input channel count.
REQ-003 The block SHALL have parameter SEL_W, default $clog2(NUM_IN), meaning select width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all buffered beats.
REQ-007 in_data  input  NUM_IN*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  channel select, sampled with the beat.
REQ-009 in_valid  input  1  upstream beat present.
REQ-010 in_ready  output  1  block can accept a beat; driven directly from a register.
REQ-011 out_data  output  WIDTH  selected data of the head beat.
REQ-012 out_err  output  1  head beat carried an out-of-range sel.
REQ-013 out_valid  output  1  head beat present.
REQ-014 out_ready  input  1  downstream takes the head beat.

Function
REQ-015 Accept SHALL occur when in_valid and in_ready are both high at a rising edge; transfer SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-016 On accept, the block SHALL capture in_data channel sel; if sel >= NUM_IN, it SHALL capture data 0 with err 1, otherwise err 0.
REQ-017 Latency SHALL be one cycle: a beat accepted at edge k appears on out_* immediately after edge k when the buffer was empty.
REQ-018 Storage SHALL be a two-entry skid buffer (head plus skid) with states EMPTY, ONE, FULL.
REQ-019 EMPTY SHALL go to ONE on accept and otherwise stay in EMPTY.
REQ-020 ONE SHALL go to FULL on accept without transfer, to EMPTY on transfer without accept, and stay in ONE on simultaneous accept and transfer, with the new beat becoming head.
REQ-021 FULL SHALL go to ONE on transfer, moving skid to head; no accept is possible in FULL.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, registered with no combinational path from out_ready.
REQ-023 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated except on flush or reset.
REQ-024 out_data and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 flush SHALL force EMPTY at the next edge with out_valid=0 and in_ready=1, discarding buffered beats and any beat offered in the same cycle; flush SHALL take priority over simultaneous accept and transfer.
REQ-026 Head and skid registers SHALL NOT change when no accept or transfer occurs, to avoid needless toggling.

Reset
REQ-027 While reset is high, and immediately on its assertion, the block SHALL hold state EMPTY, out_valid=0, out_data=0, out_err=0, in_ready=1, and skid contents 0.
REQ-028 Beats offered while reset is high SHALL be discarded; the first accept SHALL be possible at the first edge after reset deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered beats without generating any partial output.

Structure
REQ-030 The state encoding (EMPTY/ONE/FULL, 2 bits) and default parameter constants SHALL live in the shared package pipe_sel_pkg.
REQ-031 Channel selection plus range check SHALL be a combinational sub-module named sel_mux_n (parameters WIDTH, NUM_IN; outputs data and err); the buffer FSM SHALL live in pipe_sel_mux.
REQ-032 The design SHALL contain no latches; each case statement SHALL include a default assignment.

Verification
REQ-033 Reset, then sel=2, in_data ch2=0x1234_5678, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 with out_data=0x1234_5678 and out_err=0 on the next cycle only.
REQ-034 NUM_IN=3, sel=3 accepted -> out_data=0 and out_err=1.
REQ-035 out_ready=0 while beats A, B, C are offered -> A and B accepted, in_ready=0 after B; then out_ready=1 -> A, B, C delivered in order with no loss.
REQ-036 FULL state with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0 and in_ready=1; the offered beat is never output.
REQ-037 Continuous in_valid=1 and out_ready=1 for 100 beats with counting data -> 100 beats delivered in order at one per cycle, with in_ready never dropping.
REQ-038 reset asserted mid-cycle in ONE state -> out_valid=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipe_sel_pkg.sv
// Shared definitions for the pipe_sel_mux block.
//   state_e  : skid buffer occupancy (empty / one beat / two beats)
//   DefWidth : default data bits per channel
//   DefNumIn : default input channel count
package pipe_sel_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } state_e;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefNumIn = 4;

endpackage

// File: rtl/sel_mux_n.sv
// Combinational channel selector with range check.
//   in_data : NUM_IN packed channels, channel i at [i*WIDTH +: WIDTH]
//   sel     : channel select
//   data    : selected channel, or 0 when sel is out of range
//   err     : high when sel >= NUM_IN
module sel_mux_n
  import pipe_sel_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned NUM_IN = DefNumIn,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    err
);

  always_comb begin
    data = '0;
    err  = (32'(sel) >= NUM_IN);
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(sel) == i) begin
        data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_sel_mux.sv
// Channel-select mux feeding a two-entry skid buffer (head + skid).
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   flush               : synchronous discard of all buffered beats
//   in_data, sel        : packed channels and select, sampled on accept
//   in_valid / in_ready : upstream handshake; in_ready is a register
//   out_data, out_err   : head beat payload and out-of-range flag
//   out_valid/out_ready : downstream handshake
module pipe_sel_mux
  import pipe_sel_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned NUM_IN = DefNumIn,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] head_data_q, skid_data_q, head_data_d;
  logic             head_err_q, skid_err_q, head_err_d;
  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic             accept, transfer;
  logic             head_load, head_from_skid, skid_load;

  sel_mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel_mux (
    .in_data (in_data),
    .sel     (sel),
    .data    (mux_data),
    .err     (mux_err)
  );

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = in_ready_q;
  assign out_data  = head_data_q;
  assign out_err   = head_err_q;
  assign accept    = in_valid & in_ready_q;
  assign transfer  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            head_load = 1'b1;
          end
        end
        StOne: begin
          if (accept && !transfer) begin
            state_d   = StFull;
            skid_load = 1'b1;
          end else if (accept && transfer) begin
            head_load = 1'b1;
          end else if (transfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only a transfer can happen
          if (transfer) begin
            state_d        = StOne;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    head_data_d = mux_data;
    head_err_d  = mux_err;
    if (head_from_skid) begin
      head_data_d = skid_data_q;
      head_err_d  = skid_err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Registered from next state so out_ready has no combinational path here
      in_ready_q <= (state_d != StFull);
      if (head_load) begin
        head_data_q <= head_data_d;
        head_err_q  <= head_err_d;
      end
      if (skid_load) begin
        skid_data_q <= mux_data;
        skid_err_q  <= mux_err;
      end
    end
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
module tb_pipe_sel_mux;

  logic         clk = 1'b0;
  logic         reset, flush;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid, in_ready, out_err, out_valid, out_ready;
  logic [31:0]  out_data;

  logic [95:0]  in_data3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3, out_err3, out_valid3, out_ready3;
  logic [31:0]  out_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_err   (out_err3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat on the 4-channel DUT, channel sel carries d, others carry noise
  task automatic offer(input logic [1:0] s, input logic [31:0] d);
    in_data = {4{32'hDEAD_BEEF}};
    in_data[s*32 +: 32] = d;
    sel      = s;
    in_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_data = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data3 = '0; sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;

    // Reset state, with a beat offered that must be discarded
    offer(2'd1, 32'h1111_1111);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    step(); step();
    chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

    // Single beat on channel 2, one-cycle latency, present for one cycle only
    out_ready = 1'b1;
    offer(2'd2, 32'h1234_5678);
    step();
    in_valid = 1'b0;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", out_data, 32'h1234_5678);
    chk("single_err", {31'd0, out_err}, 32'd0);
    step();
    chk("single_gone", {31'd0, out_valid}, 32'd0);

    // Highest in-range channel on the 4-channel DUT
    offer(2'd3, 32'h3333_CAFE);
    step();
    in_valid = 1'b0;
    chk("ch3_data", out_data, 32'h3333_CAFE);
    chk("ch3_err", {31'd0, out_err}, 32'd0);
    step();

    // NUM_IN=3: sel=3 out of range gives data 0 and err 1; sel=2 is valid
    in_data3 = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    sel3 = 2'd3; in_valid3 = 1'b1;
    step();
    chk("oor_valid", {31'd0, out_valid3}, 32'd1);
    chk("oor_data", out_data3, 32'd0);
    chk("oor_err", {31'd0, out_err3}, 32'd1);
    sel3 = 2'd2;
    step();
    in_valid3 = 1'b0;
    chk("n3_ch2_data", out_data3, 32'hC2C2_C2C2);
    chk("n3_ch2_err", {31'd0, out_err3}, 32'd0);
    step();
    chk("n3_empty", {31'd0, out_valid3}, 32'd0);

    // Backpressure: A, B accepted, C held off; then drain in order
    out_ready = 1'b0;
    offer(2'd0, 32'hAAAA_0001);
    step();
    chk("bp_A_head", out_data, 32'hAAAA_0001);
    chk("bp_A_ready", {31'd0, in_ready}, 32'd1);
    offer(2'd1, 32'hBBBB_0002);
    step();
    chk("bp_B_full", {31'd0, in_ready}, 32'd0);
    chk("bp_B_head", out_data, 32'hAAAA_0001);
    offer(2'd2, 32'hCCCC_0003);
    step();
    chk("bp_C_blocked", {31'd0, in_ready}, 32'd0);
    chk("bp_A_stable", out_data, 32'hAAAA_0001);
    out_ready = 1'b1;
    step();
    chk("bp_out_B", out_data, 32'hBBBB_0002);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_C", out_data, 32'hCCCC_0003);
    chk("bp_C_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush while full, with a beat offered in the same cycle
    out_ready = 1'b0;
    offer(2'd0, 32'hD000_0004);
    step();
    offer(2'd0, 32'hE000_0005);
    step();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    offer(2'd0, 32'hF000_0006);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", {31'd0, out_valid}, 32'd0);

    // Flush wins over simultaneous accept and transfer in ONE
    offer(2'd1, 32'h0A0A_0A0A);
    step();
    flush = 1'b1;
    offer(2'd1, 32'h0B0B_0B0B);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_prio_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("fl_prio_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: 100 counting beats, one per cycle, in_ready never drops
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      offer(2'd1, 32'(i + 32'h100));
      step();
      chk("stream_data", out_data, 32'(i + 32'h100));
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle in ONE
    out_ready = 1'b0;
    offer(2'd3, 32'h5555_AAAA);
    step();
    in_valid = 1'b0;
    chk("ar_one", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_stays_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
